// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator (IFU/LSU) and a memory responder.
// Each direction uses its own valid/ready handshake.
interface mem_responder_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_wmask;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Single-port memory responder: one outstanding request, fixed access delay,
// word reads and byte-masked writes on a byte-lane split block RAM.
module mem_responder #(
  parameter int unsigned       ADDR_W  = 32,
  parameter int unsigned       DEPTH   = 1024,
  parameter logic [ADDR_W-1:0] BASE    = ADDR_W'(32'h8000_0000),
  parameter int unsigned       LATENCY = 2
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);
  localparam int unsigned       IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(4 * DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rdy_q;
  logic              err_q;
  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wmask_q;

  logic              accept;
  logic              enter_resp;
  logic              mem_en;
  logic              acc_wen;
  logic [ADDR_W-1:0] acc_addr;
  logic [ADDR_W-1:0] acc_off;
  logic [31:0]       acc_wdata;
  logic [3:0]        acc_wmask;
  logic              acc_in_range;
  logic [IDX_W-1:0]  acc_idx;
  logic [31:0]       rd_word;

  assign accept     = (state_q == IDLE) && rdy_q && bus.req_valid;
  assign enter_resp = (state_q != RESP) && (state_d == RESP);
  assign mem_en     = enter_resp && acc_in_range && !rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // With zero latency the array is touched on the accept edge itself, so the
  // live request fields are used instead of the (not yet loaded) latches.
  always_comb begin
    if (state_q == IDLE) begin
      acc_wen   = bus.req_wen;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
      acc_wmask = bus.req_wmask;
    end else begin
      acc_wen   = wen_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_wmask = wmask_q;
    end
    acc_off      = acc_addr - BASE;
    acc_in_range = (acc_off < SPAN);
    acc_idx      = IDX_W'(acc_off >> 2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= (state_d == IDLE);
      if (accept) begin
        wen_q   <= bus.req_wen;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        wmask_q <= bus.req_wmask;
      end
      if (enter_resp) begin
        err_q <= !acc_in_range;
      end
    end
  end

  // One byte-wide RAM per lane keeps the per-lane write enable trivially mappable.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_q [DEPTH];
      logic [7:0] rd_lane_q;

      always_ff @(posedge clk) begin
        if (mem_en) begin
          if (acc_wen) begin
            if (acc_wmask[gi]) begin
              lane_q[acc_idx] <= acc_wdata[8*gi +: 8];
            end
          end else begin
            rd_lane_q <= lane_q[acc_idx];
          end
        end
      end

      assign rd_word[8*gi +: 8] = rd_lane_q;
    end
  endgenerate

  assign bus.req_ready  = rdy_q;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_err   = (state_q == RESP) && err_q;
  assign bus.resp_rdata = ((state_q == RESP) && !err_q && !wen_q) ? rd_word : 32'h0;
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: directed cases plus random traffic checked
// against a word-array reference model with randomized response back-pressure.
module tb_mem_responder;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned LATENCY = 2;
  localparam logic [31:0] BASE    = 32'h8000_0000;
  localparam logic [31:0] TOP     = BASE + 32'(4 * DEPTH);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_W(ADDR_W)) bus ();

  mem_responder #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .BASE   (BASE),
    .LATENCY(LATENCY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
    bit          wen;
    logic [31:0] addr;
  } exp_t;

  exp_t        sb[$];
  bit   [31:0] model[int];
  logic [31:0] pool[8];
  logic [31:0] oor[4];

  int n_vec   = 0;
  int n_miss  = 0;
  int cyc     = 0;
  int bp_hold = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h, expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: byte-addressed window [BASE, TOP) of 32-bit words, index = offset/4.
  task automatic issue(input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wmask, input bit commit);
    int          k;
    exp_t        e;
    logic [31:0] off;
    int          idx;
    bit   [31:0] w;
    bus.req_valid = 1'b1;
    bus.req_wen   = wen;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_wmask = wmask;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.req_ready && k < 300);
    if (!bus.req_ready) begin
      chk("accept_timeout", {31'b0, bus.req_ready}, 32'd1);
    end
    off       = addr - BASE;
    idx       = int'(off >> 2);
    e.acc_cyc = cyc;
    e.wen     = wen;
    e.addr    = addr;
    if (off >= 32'(4 * DEPTH)) begin
      e.err   = 1'b1;
      e.rdata = 32'h0;
    end else if (wen) begin
      e.err   = 1'b0;
      e.rdata = 32'h0;
      if (commit) begin
        w = model.exists(idx) ? model[idx] : 32'h0;
        for (int b = 0; b < 4; b++) begin
          if (wmask[b]) w[8*b +: 8] = wdata[8*b +: 8];
        end
        model[idx] = w;
      end
    end else begin
      e.err   = 1'b0;
      e.rdata = model.exists(idx) ? model[idx] : 32'hx;
    end
    if (commit) sb.push_back(e);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_wen   = 1'bx;
    bus.req_addr  = 'x;
    bus.req_wdata = 'x;
    bus.req_wmask = 'x;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() > 0 && k < 500) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  // Response back-pressure: random, or forced low while bp_hold counts down.
  initial begin
    bus.resp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_hold > 0) begin
        bus.resp_ready = 1'b0;
        bp_hold--;
      end else begin
        bus.resp_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: pops the scoreboard on each response handshake.
  logic        prev_v, prev_hs, prev_e;
  logic [31:0] prev_d;
  int          first_cyc;
  exp_t        got;
  initial begin
    prev_v    = 1'b0;
    prev_hs   = 1'b0;
    prev_e    = 1'b0;
    prev_d    = 32'h0;
    first_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v  = 1'b0;
        prev_hs = 1'b0;
      end else begin
        if (prev_hs) chk("req_ready_after_hs", {31'b0, bus.req_ready}, 32'd1);
        if (bus.resp_valid) begin
          chk("req_ready_while_resp", {31'b0, bus.req_ready}, 32'd0);
          if (!prev_v) begin
            first_cyc = cyc;
          end else begin
            chk("hold_rdata", bus.resp_rdata, prev_d);
            chk("hold_err", {31'b0, bus.resp_err}, {31'b0, prev_e});
          end
          if (bus.resp_ready) begin
            if (sb.size() == 0) begin
              chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
              got = sb.pop_front();
              $display("txn %s addr=%08h rdata=%08h err=%0b latency=%0d",
                       got.wen ? "WR" : "RD", got.addr, bus.resp_rdata, bus.resp_err,
                       first_cyc - got.acc_cyc);
              chk("resp_rdata", bus.resp_rdata, got.rdata);
              chk("resp_err", {31'b0, bus.resp_err}, {31'b0, got.err});
              chk("resp_latency", 32'(first_cyc - got.acc_cyc), 32'(LATENCY + 1));
            end
          end
        end
        prev_hs = bus.resp_valid && bus.resp_ready;
        prev_v  = bus.resp_valid && !bus.resp_ready;
        prev_d  = bus.resp_rdata;
        prev_e  = bus.resp_err;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_mask;
  bit          r_wen;
  int          r_sel;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_wen   = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wmask = '0;
    pool[0] = BASE;
    pool[1] = TOP - 32'd4;
    pool[2] = BASE + 32'h10;
    pool[3] = BASE + 32'h20;
    for (int i = 4; i < 8; i++) pool[i] = BASE + 32'(4 * $urandom_range(16, DEPTH - 2));
    oor[0] = 32'h7FFF_FFFC;
    oor[1] = TOP;
    oor[2] = 32'h0000_0000;
    oor[3] = 32'hFFFF_FFFC;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_resp_err", {31'b0, bus.resp_err}, 32'd0);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("req_ready_after_rst", {31'b0, bus.req_ready}, 32'd1);

    // Full write then read-back of the same word.
    issue(1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1);
    issue(1'b0, BASE + 32'h10, 32'h0, 4'h0, 1'b1);
    // Partial byte-lane write over a known word.
    issue(1'b1, BASE + 32'h20, 32'h1122_3344, 4'hF, 1'b1);
    issue(1'b1, BASE + 32'h20, 32'hAABB_CCDD, 4'b0101, 1'b1);
    issue(1'b0, BASE + 32'h20, 32'h0, 4'h0, 1'b1);
    for (int i = 0; i < 8; i++) issue(1'b1, pool[i], $urandom, 4'hF, 1'b1);

    // Out-of-range accesses, then confirm the edge words are untouched.
    issue(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 1'b1);
    issue(1'b0, TOP, 32'h0, 4'h0, 1'b1);
    issue(1'b1, TOP, 32'h5555_5555, 4'hF, 1'b1);
    issue(1'b1, BASE - 32'd4, 32'h6666_6666, 4'hF, 1'b1);
    issue(1'b0, pool[0], 32'h0, 4'h0, 1'b1);
    issue(1'b0, pool[1], 32'h0, 4'h0, 1'b1);

    // Long back-pressure while a new request waits on the bus.
    drain();
    bp_hold = LATENCY + 8;
    issue(1'b0, pool[2], 32'h0, 4'h0, 1'b1);
    issue(1'b0, pool[3], 32'h0, 4'h0, 1'b1);

    for (int t = 0; t < 250; t++) begin
      r_wen   = ($urandom_range(0, 2) == 0);
      r_sel   = $urandom_range(0, 9);
      r_addr  = (r_sel < 8) ? (pool[r_sel] | 32'($urandom_range(0, 3))) : oor[r_sel - 8];
      r_wdata = $urandom;
      r_mask  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) r_addr = oor[$urandom_range(0, 3)];
      issue(r_wen, r_addr, r_wdata, r_mask, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    // Reset during the wait phase of a write: the write must never land.
    drain();
    issue(1'b1, pool[2], 32'hCAFE_F00D, 4'hF, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    chk("midrst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("midrst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("midrst_resp_err", {31'b0, bus.resp_err}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("req_ready_after_midrst", {31'b0, bus.req_ready}, 32'd1);
    issue(1'b0, pool[2], 32'h0, 4'h0, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
